// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the byte-wide memory.
// Grant and memory strobe are combinational from the arbiter's state; rvalid and rdata are registered.
// A requester holds req and its payload until it sees gnt; ownership persists while lock is high.
//
// Port summary:
//   c_* / d_*   core and loader request, lock, we, addr, wdata in; gnt and rvalid out
//   rdata       registered read data shared by both requesters
//   mem_*       single-port memory strobe, write enable, address, write data out; read data in
//
// The slave modport is the arbiter's view. The master modport is everything around it:
// both requesters plus the memory, which supplies mem_rdata.
interface mips_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          c_req;
    logic          c_lock;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_rvalid;

    logic          d_req;
    logic          d_lock;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  c_req, c_lock, c_we, c_addr, c_wdata,
        input  d_req, d_lock, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output c_gnt, c_rvalid, d_gnt, d_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output c_req, c_lock, c_we, c_addr, c_wdata,
        output d_req, d_lock, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  c_gnt, c_rvalid, d_gnt, d_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter for the multicycle MIPS unified byte memory: core (C) vs loader/DMA (D).
// Latency: 1 arbitration cycle from IDLE; no gap on OWN-to-OWN handover; read data 1 cycle after accept.
// Backpressure: a requester is stalled by gnt=0 until it owns the bus; a lock holds ownership up to LOCK_MAX cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset; drops any in-flight read
//   bus    mips_mem_arbiter_if.slave (requests, grants, rvalid/rdata, memory side)
//
// LOCK_MAX must be at least 4 so a locked 4-byte instruction fetch is never split.
module mips_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    mips_mem_arbiter_if.slave  bus
);

    localparam int HW = $clog2(LOCK_MAX + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LOCK_MAX);
    localparam logic [HW-1:0] HOLD_REL = HW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t        state;
    logic          rr_last;      // last owner: 0 = C, 1 = D
    logic [HW-1:0] hold_cnt;     // cycles spent in the current OWN state
    logic          rv_c;
    logic          rv_d;
    logic [DW-1:0] rdata_q;

    // ------------------------------------------------------------------
    // Owner-relative views, so the OWN_C / OWN_D transition rules share one body.
    // ------------------------------------------------------------------
    logic own_c;
    logic own_d;
    logic own_req;               // x_req of the current owner
    logic own_lock;              // x_lock of the current owner
    logic oth_req;               // y_req of the non-owner

    assign own_c    = (state == OWN_C);
    assign own_d    = (state == OWN_D);
    assign own_req  = own_d ? bus.d_req  : bus.c_req;
    assign own_lock = own_d ? bus.d_lock : bus.c_lock;
    assign oth_req  = own_d ? bus.c_req  : bus.d_req;

    // ------------------------------------------------------------------
    // Grants and memory strobe: combinational from state and the owner's request,
    // so an owner is accepted in the same cycle it asks.
    // ------------------------------------------------------------------
    logic          c_gnt;
    logic          d_gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign c_gnt     = own_c & bus.c_req;
    assign d_gnt     = own_d & bus.d_req;
    assign sel_we    = own_d ? bus.d_we    : bus.c_we;
    assign sel_addr  = own_d ? bus.d_addr  : bus.c_addr;
    assign sel_wdata = own_d ? bus.d_wdata : bus.c_wdata;

    assign bus.c_gnt     = c_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = c_gnt | d_gnt;
    // Write enable is qualified by the strobe so a stray we in IDLE or in a
    // held-but-idle lock never reaches the memory.
    assign bus.mem_we    = (c_gnt | d_gnt) & sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    assign bus.c_rvalid  = rv_c;
    assign bus.d_rvalid  = rv_d;
    assign bus.rdata     = rdata_q;

    // Forced release: the owner has used its full hold budget and the other side is waiting.
    // ">=" rather than "==" so a counter that saturated while the owner was alone
    // still yields as soon as the other side starts requesting.
    logic force_rel;
    assign force_rel = oth_req && (hold_cnt >= HOLD_REL);

    logic rd_acc;
    assign rd_acc = (c_gnt & ~bus.c_we) | (d_gnt & ~bus.d_we);

    // ------------------------------------------------------------------
    // State, round-robin pointer, hold counter and registered read return.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_last  <= 1'b1;    // D counts as last owner, so C wins the first tie
            hold_cnt <= '0;
            rv_c     <= 1'b0;
            rv_d     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            // One rvalid pulse per accepted read, aligned with the captured data.
            rv_c <= c_gnt & ~bus.c_we;
            rv_d <= d_gnt & ~bus.d_we;
            if (rd_acc) begin
                rdata_q <= bus.mem_rdata;
            end

            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (bus.c_req && (!bus.d_req || rr_last)) begin
                        state <= OWN_C;
                    end else if (bus.d_req) begin
                        state <= OWN_D;
                    end
                end

                OWN_C, OWN_D: begin
                    if (force_rel || (!own_lock && oth_req)) begin
                        // Hand straight over; the current cycle's accept still completes.
                        state    <= own_d ? OWN_C : OWN_D;
                        rr_last  <= own_d;
                        hold_cnt <= '0;
                    end else if (own_lock || own_req) begin
                        // Keep ownership; a lock holds it even with no request (mem_en=0).
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end else begin
                        state    <= IDLE;
                        rr_last  <= own_d;
                        hold_cnt <= '0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: per-cycle vector table plus hand-written reset/lock sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The memory model reads combinationally from mem_addr and writes on the rising edge.
module tb_mips_mem_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mips_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory: location i initially holds 0xA0 + i.
    logic [7:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hA0 + 8'(i);
        forever begin
            @(posedge clk);
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One record per clock cycle: inputs, then outputs expected in that same cycle.
    typedef struct {
        logic [2:0] c;       // {req, lock, we}
        logic [7:0] ca, cw;
        logic [2:0] d;
        logic [7:0] da, dw;
        logic [3:0] e;       // {c_gnt, d_gnt, mem_en, mem_we}
        logic [7:0] ea, ew;  // mem_addr (checked when mem_en), mem_wdata (checked when mem_we)
        logic [1:0] rv;      // {c_rvalid, d_rvalid}
        logic [7:0] rd;      // rdata
    } vec_t;

    function automatic vec_t v(input logic [2:0] c, input logic [7:0] ca, cw,
                               input logic [2:0] d, input logic [7:0] da, dw,
                               input logic [3:0] e, input logic [7:0] ea, ew,
                               input logic [1:0] rv, input logic [7:0] rd);
        vec_t t;
        t.c = c; t.ca = ca; t.cw = cw; t.d = d; t.da = da; t.dw = dw;
        t.e = e; t.ea = ea; t.ew = ew; t.rv = rv; t.rd = rd;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        {bus.c_req, bus.c_lock, bus.c_we} = t.c;
        bus.c_addr  = t.ca;
        bus.c_wdata = t.cw;
        {bus.d_req, bus.d_lock, bus.d_we} = t.d;
        bus.d_addr  = t.da;
        bus.d_wdata = t.dw;
    endtask

    task automatic idle_inputs();
        drive(v(3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 2'b00, 8'h00));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();

        // ---------------- vector table ----------------
        //                c      ca     cw     d      da     dw     e        ea     ew     rv     rd
        // idle after reset
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'h00)); // 0
        // core locked read burst 0..3
        tbl.push_back(v(3'b110,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'h00)); // 1 IDLE
        tbl.push_back(v(3'b110,8'h00,8'h00,3'b000,8'h00,8'h00,4'b1010,8'h00,8'h00,2'b00,8'h00)); // 2
        tbl.push_back(v(3'b110,8'h01,8'h00,3'b000,8'h00,8'h00,4'b1010,8'h01,8'h00,2'b10,8'hA0)); // 3
        tbl.push_back(v(3'b110,8'h02,8'h00,3'b000,8'h00,8'h00,4'b1010,8'h02,8'h00,2'b10,8'hA1)); // 4
        tbl.push_back(v(3'b110,8'h03,8'h00,3'b000,8'h00,8'h00,4'b1010,8'h03,8'h00,2'b10,8'hA2)); // 5
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b10,8'hA3)); // 6 -> IDLE
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'hA3)); // 7
        // contention, C was last owner so D wins the tie, then alternate
        tbl.push_back(v(3'b100,8'h01,8'h00,3'b100,8'h02,8'h00,4'b0000,8'h00,8'h00,2'b00,8'hA3)); // 8 IDLE
        tbl.push_back(v(3'b100,8'h01,8'h00,3'b100,8'h02,8'h00,4'b0110,8'h02,8'h00,2'b00,8'hA3)); // 9 D
        tbl.push_back(v(3'b100,8'h01,8'h00,3'b100,8'h02,8'h00,4'b1010,8'h01,8'h00,2'b01,8'hA2)); // 10 C
        tbl.push_back(v(3'b100,8'h01,8'h00,3'b100,8'h02,8'h00,4'b0110,8'h02,8'h00,2'b10,8'hA1)); // 11 D
        tbl.push_back(v(3'b100,8'h01,8'h00,3'b000,8'h00,8'h00,4'b1010,8'h01,8'h00,2'b01,8'hA2)); // 12 C
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b10,8'hA1)); // 13 -> IDLE
        // loader write 0x5C to 0x10, then read it back
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b101,8'h10,8'h5C,4'b0000,8'h00,8'h00,2'b00,8'hA1)); // 14 IDLE
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b101,8'h10,8'h5C,4'b0111,8'h10,8'h5C,2'b00,8'hA1)); // 15 write
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b100,8'h10,8'h00,4'b0110,8'h10,8'h00,2'b00,8'hA1)); // 16 read
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b01,8'h5C)); // 17
        // core lock held with no request
        tbl.push_back(v(3'b110,8'h03,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'h5C)); // 18 IDLE
        tbl.push_back(v(3'b110,8'h03,8'h00,3'b000,8'h00,8'h00,4'b1010,8'h03,8'h00,2'b00,8'h5C)); // 19
        tbl.push_back(v(3'b010,8'h03,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b10,8'hA3)); // 20 held
        tbl.push_back(v(3'b010,8'h03,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'hA3)); // 21 held
        tbl.push_back(v(3'b010,8'h03,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'hA3)); // 22 held
        tbl.push_back(v(3'b100,8'h03,8'h00,3'b000,8'h00,8'h00,4'b1010,8'h03,8'h00,2'b00,8'hA3)); // 23 still owner
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b10,8'hA3)); // 24 -> IDLE
        tbl.push_back(v(3'b100,8'h03,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'hA3)); // 25 IDLE
        tbl.push_back(v(3'b000,8'h00,8'h00,3'b000,8'h00,8'h00,4'b0000,8'h00,8'h00,2'b00,8'hA3)); // 26 -> IDLE

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst c_gnt",    bus.c_gnt,    0);
        check("rst d_gnt",    bus.d_gnt,    0);
        check("rst mem_en",   bus.mem_en,   0);
        check("rst mem_we",   bus.mem_we,   0);
        check("rst c_rvalid", bus.c_rvalid, 0);
        check("rst d_rvalid", bus.d_rvalid, 0);
        check("rst rdata",    bus.rdata,    0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table run ----------------
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d c_gnt", i),    bus.c_gnt,    tbl[i].e[3]);
            check($sformatf("vec%0d d_gnt", i),    bus.d_gnt,    tbl[i].e[2]);
            check($sformatf("vec%0d mem_en", i),   bus.mem_en,   tbl[i].e[1]);
            check($sformatf("vec%0d mem_we", i),   bus.mem_we,   tbl[i].e[0]);
            if (tbl[i].e[1]) check($sformatf("vec%0d mem_addr", i), bus.mem_addr, tbl[i].ea);
            if (tbl[i].e[0]) check($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, tbl[i].ew);
            check($sformatf("vec%0d c_rvalid", i), bus.c_rvalid, tbl[i].rv[1]);
            check($sformatf("vec%0d d_rvalid", i), bus.d_rvalid, tbl[i].rv[0]);
            check($sformatf("vec%0d rdata", i),    bus.rdata,    tbl[i].rd);
            @(posedge clk);
            #1;
        end

        // ---------------- first tie after reset: C first, then C,D,C,D ----------------
        do_reset();
        bus.c_req = 1'b1; bus.c_addr = 8'h00;
        bus.d_req = 1'b1; bus.d_addr = 8'h01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("alt%0d c_gnt", k), bus.c_gnt, (k % 2) == 1);
            check($sformatf("alt%0d d_gnt", k), bus.d_gnt, (k != 0) && ((k % 2) == 0));
            if (k != 0) check($sformatf("alt%0d mem_addr", k), bus.mem_addr, (k % 2) == 1 ? 8'h00 : 8'h01);
            if (k >= 2) begin
                check($sformatf("alt%0d c_rvalid", k), bus.c_rvalid, (k % 2) == 0);
                check($sformatf("alt%0d rdata", k), bus.rdata, (k % 2) == 0 ? 8'hA0 : 8'hA1);
            end
            @(posedge clk);
            #1;
        end

        // ---------------- lock bound: C owns exactly LOCK_MAX cycles ----------------
        do_reset();
        bus.c_req = 1'b1; bus.c_lock = 1'b1; bus.c_addr = 8'h03;
        bus.d_req = 1'b1; bus.d_addr = 8'h01;
        for (int k = 0; k <= LOCK_MAX + 2; k++) begin
            @(negedge clk);
            check($sformatf("lock%0d c_gnt", k), bus.c_gnt,
                  ((k >= 1) && (k <= LOCK_MAX)) || (k == LOCK_MAX + 2));
            check($sformatf("lock%0d d_gnt", k), bus.d_gnt, k == LOCK_MAX + 1);
            @(posedge clk);
            #1;
        end

        // ---------------- reset in the middle of a read ----------------
        do_reset();
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h02;
        @(negedge clk);
        check("mid idle c_gnt", bus.c_gnt, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid accept c_gnt", bus.c_gnt, 1);
        reset = 1'b0;
        #1;
        check("mid rst c_gnt",    bus.c_gnt,    0);
        check("mid rst d_gnt",    bus.d_gnt,    0);
        check("mid rst mem_en",   bus.mem_en,   0);
        check("mid rst mem_we",   bus.mem_we,   0);
        check("mid rst c_rvalid", bus.c_rvalid, 0);
        check("mid rst rdata",    bus.rdata,    0);
        @(posedge clk);
        #1;
        check("mid rst hold c_rvalid", bus.c_rvalid, 0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid post c_rvalid", bus.c_rvalid, 0);
        bus.d_req = 1'b1; bus.d_addr = 8'h03;
        @(negedge clk);
        check("mid post d_gnt idle", bus.d_gnt, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid post d_gnt", bus.d_gnt, 1);
        check("mid post c_rvalid2", bus.c_rvalid, 0);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        @(negedge clk);
        check("mid post d_rvalid", bus.d_rvalid, 1);
        check("mid post rdata", bus.rdata, 8'hA3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
